// File: rtl/meter_pkg.sv
// rtl/meter_pkg.sv - shared types and constants for the peak/mean-absolute level meter
package meter_pkg;

   localparam int SAMPLE_W = 16;
   localparam int MAG_W    = SAMPLE_W - 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      REPORT  = 2'd2
   } meter_state_t;

   // Full-scale codes; either one counts as a clipped sample.
   localparam logic signed [SAMPLE_W-1:0] POS_FS = 16'sh7FFF;
   localparam logic signed [SAMPLE_W-1:0] NEG_FS = 16'sh8000;

   function automatic logic is_clip(input logic signed [SAMPLE_W-1:0] x);
      return (x == POS_FS) || (x == NEG_FS);
   endfunction

endpackage

// File: rtl/sample_abs.sv
// rtl/sample_abs.sv - saturated magnitude of a signed sample; -32768 folds onto 32767
module sample_abs
   import meter_pkg::*;
(
   input  logic signed [SAMPLE_W-1:0] sampleIn,
   output logic        [SAMPLE_W-1:0] magOut
);

   logic signed [SAMPLE_W-1:0] negated;

   always_comb begin
      negated = -sampleIn;
      magOut  = '0;
      if (sampleIn == NEG_FS) begin
         magOut = $unsigned(POS_FS);
      end else if (sampleIn[SAMPLE_W-1]) begin
         magOut = $unsigned(negated);
      end else begin
         magOut = $unsigned(sampleIn);
      end
   end

endmodule

// File: rtl/peak_meter.sv
// rtl/peak_meter.sv - windowed peak, mean-absolute and clip detector for a filter output stream
module peak_meter
   import meter_pkg::*;
#(
   parameter int WINDOW_LOG2 = 6
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       sampleValid,
   input  logic signed [SAMPLE_W-1:0] sampleIn,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic        [SAMPLE_W-1:0] peakOut,
   output logic        [SAMPLE_W-1:0] meanAbsOut,
   output logic                       clipOut
);

   localparam int ACC_W = MAG_W + WINDOW_LOG2;

   meter_state_t state, state_next;

   logic [WINDOW_LOG2-1:0] count;
   logic [SAMPLE_W-1:0]    peak;
   logic [ACC_W-1:0]       acc;
   logic                   clip;

   logic [SAMPLE_W-1:0]    mag;
   logic [SAMPLE_W-1:0]    peak_nxt;
   logic [ACC_W-1:0]       acc_nxt;
   logic                   clip_nxt;
   logic [ACC_W-1:0]       mean_full;

   logic clear;
   logic accept;
   logic load;

   sample_abs u_abs (
      .sampleIn (sampleIn),
      .magOut   (mag)
   );

   // Running values including the sample on the input now; the final
   // sample of a window goes straight into the result registers.
   always_comb begin
      peak_nxt  = (mag > peak) ? mag : peak;
      acc_nxt   = acc + ACC_W'(mag);
      clip_nxt  = clip | is_clip(sampleIn);
      mean_full = acc_nxt >> WINDOW_LOG2;
   end

   always_comb begin
      state_next = state;
      clear      = 1'b0;
      accept     = 1'b0;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = MEASURE;
               clear      = 1'b1;
            end
         end
         MEASURE: begin
            if (sampleValid) begin
               accept = 1'b1;
               if (&count) begin
                  state_next = REPORT;
                  load       = 1'b1;
               end
            end
         end
         REPORT: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
         peak  <= '0;
         acc   <= '0;
         clip  <= 1'b0;
      end else if (clear) begin
         count <= '0;
         peak  <= '0;
         acc   <= '0;
         clip  <= 1'b0;
      end else if (accept) begin
         count <= count + 1'b1;
         peak  <= peak_nxt;
         acc   <= acc_nxt;
         clip  <= clip_nxt;
      end
   end

   // busy and done are registered from the next-state decode so they line up with the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy       <= 1'b0;
         done       <= 1'b0;
         peakOut    <= '0;
         meanAbsOut <= '0;
         clipOut    <= 1'b0;
      end else begin
         busy <= (state_next != IDLE);
         done <= load;
         if (load) begin
            peakOut    <= peak_nxt;
            meanAbsOut <= SAMPLE_W'(mean_full);
            clipOut    <= clip_nxt;
         end
      end
   end

endmodule
